// File: rtl/pll_seq_pkg.sv
// ============================================================================
// Module  : pll_seq_pkg
// Brief   : Shared types, default constants and helpers for the PLL sequencer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package pll_seq_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    RUN       = 2'd2,
    FAULT     = 2'd3
  } pll_state_e;

  localparam int unsigned DEF_RST_CYCLES   = 10;
  localparam int unsigned DEF_LOCK_STABLE  = 1024;
  localparam int unsigned DEF_LOCK_TIMEOUT = 50000;
  localparam int unsigned DEF_MAX_RETRIES  = 7;
  localparam int unsigned DEF_CNT_W        = 16;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module  : sync_2ff
// Brief   : Single-bit two-flop synchronizer, async active-high reset to 0.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
// ============================================================================
// Module  : pll_reset_sequencer
// Brief   : Pulses the PLL reset, waits for debounced lock with timeout/retry,
//           and holds pixel logic in reset until the clock is stable.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_CYCLES   = DEF_RST_CYCLES,
  parameter int unsigned LOCK_STABLE  = DEF_LOCK_STABLE,
  parameter int unsigned LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int unsigned MAX_RETRIES  = DEF_MAX_RETRIES,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked_i,
  input  logic       soft_reset_i,
  input  logic       clear_fault_i,
  output logic       pll_rst_o,
  output logic       pixel_rst_o,
  output logic       ready_o,
  output logic       fault_o,
  output logic [2:0] retry_count_o,
  output logic [7:0] loss_count_o
);

  localparam logic [CNT_W-1:0] C_RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_STABLE    = CNT_W'(LOCK_STABLE);
  localparam logic [CNT_W-1:0] C_TIMEOUT   = CNT_W'(LOCK_TIMEOUT);
  localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);
  localparam logic [2:0]       C_RETRY_MAX = 3'(MAX_RETRIES);

  pll_state_e       state_q, state_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic [CNT_W-1:0] stab_q, stab_d;
  logic [2:0]       retry_q, retry_d;
  logic [7:0]       loss_q, loss_d;
  logic             pll_rst_q, pixel_rst_q, ready_q, fault_q;

  logic             w_locked_s;
  logic [CNT_W-1:0] w_tmo_inc;
  logic [CNT_W-1:0] w_stab_inc;

  sync_2ff u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d_i (locked_i),
    .q_o (w_locked_s)
  );

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q     <= PLL_RST;
      tmo_q       <= '0;
      stab_q      <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      pll_rst_q   <= 1'b1;
      pixel_rst_q <= 1'b1;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      stab_q      <= stab_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      // Outputs follow the next state so they change on the same edge.
      pll_rst_q   <= (state_d == PLL_RST) || (state_d == FAULT);
      pixel_rst_q <= (state_d != RUN);
      ready_q     <= (state_d == RUN);
      fault_q     <= (state_d == FAULT);
    end
  end

  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    stab_d     = stab_q;
    retry_d    = retry_q;
    loss_d     = loss_q;
    w_tmo_inc  = tmo_q + C_ONE;
    w_stab_inc = w_locked_s ? (stab_q + C_ONE) : '0;

    if (soft_reset_i && (state_q != FAULT)) begin
      state_d = PLL_RST;
      tmo_d   = '0;
      stab_d  = '0;
      retry_d = '0;
    end else if (clear_fault_i && (state_q == FAULT)) begin
      state_d = PLL_RST;
      tmo_d   = '0;
      stab_d  = '0;
      retry_d = '0;
    end else begin
      unique case (state_q)
        // tmo_q doubles as the reset-pulse length counter here.
        PLL_RST: begin
          if (tmo_q == C_RST_LAST) begin
            state_d = WAIT_LOCK;
            tmo_d   = '0;
            stab_d  = '0;
          end else begin
            tmo_d = w_tmo_inc;
          end
        end
        WAIT_LOCK: begin
          tmo_d  = w_tmo_inc;
          stab_d = w_stab_inc;
          if (w_stab_inc == C_STABLE) begin
            state_d = RUN;
            tmo_d   = '0;
            stab_d  = '0;
            retry_d = '0;
          end else if (w_tmo_inc == C_TIMEOUT) begin
            tmo_d  = '0;
            stab_d = '0;
            if (retry_q == C_RETRY_MAX) begin
              state_d = FAULT;
            end else begin
              state_d = PLL_RST;
              retry_d = retry_q + 3'd1;
            end
          end
        end
        RUN: begin
          if (!w_locked_s) begin
            state_d = PLL_RST;
            loss_d  = sat_inc8(loss_q);
          end
        end
        FAULT: begin
          state_d = FAULT;
        end
        default: begin
          state_d = PLL_RST;
          tmo_d   = '0;
          stab_d  = '0;
        end
      endcase
    end
  end

  assign pll_rst_o     = pll_rst_q;
  assign pixel_rst_o   = pixel_rst_q;
  assign ready_o       = ready_q;
  assign fault_o       = fault_q;
  assign retry_count_o = retry_q;
  assign loss_count_o  = loss_q;

endmodule

`default_nettype wire
